// File: rtl/layer_max_finder_pkg.sv
// Shared definitions for the output-layer max finder: FSM encoding and default widths.
package layer_max_finder_pkg;

  // Width of one neuron activation as stored in the weight/activation ROMs.
  localparam int ROM_BITWIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/layer_max_finder_max_cmp_stage.sv
// Combinational compare/select: keeps the current winner unless the candidate is strictly larger.
module max_cmp_stage #(
  parameter int VAL_W = 8,
  parameter int IDX_W = 4
) (
  input  logic [VAL_W-1:0] cur_val,
  input  logic [IDX_W-1:0] cur_idx,
  input  logic [VAL_W-1:0] cand_val,
  input  logic [IDX_W-1:0] cand_idx,
  output logic [VAL_W-1:0] win_val,
  output logic [IDX_W-1:0] win_idx
);

  // Candidates always carry a higher index, so strict > keeps the lowest index on ties.
  always_comb begin
    win_val = cur_val;
    win_idx = cur_idx;
    if (cand_val > cur_val) begin
      win_val = cand_val;
      win_idx = cand_idx;
    end
  end

endmodule

// File: rtl/layer_max_finder.sv
// Captures all output-layer activations on i_valid, scans one per cycle, reports the argmax index.
// Optional MAX_FINDER_SCORE_EN adds o_max_value and a saturating 16-bit result counter.
module layer_max_finder
  import layer_max_finder_pkg::*;
#(
  parameter int numInput   = 10,
  parameter int inputWidth = ROM_BITWIDTH,
  parameter int idxWidth   = ($clog2(numInput) > 0 ? $clog2(numInput) : 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numInput*inputWidth-1:0] i_data,
  input  logic                           i_valid,
  output logic                           o_ready,
  output logic [idxWidth-1:0]            o_data,
  output logic                           o_valid,
  output logic                           o_dropped
`ifdef MAX_FINDER_SCORE_EN
  ,
  output logic [inputWidth-1:0]          o_max_value
`endif
);

  // Handshake: a frame is accepted on any clock edge where i_valid && o_ready;
  // i_valid while !o_ready is discarded and flagged on o_dropped the next cycle.

  localparam logic [idxWidth:0] LAST = (idxWidth+1)'(numInput - 1);

  state_t state_q, state_d;

  logic [inputWidth-1:0] cap_buf [numInput];
  logic [inputWidth-1:0] max_val;
  logic [idxWidth-1:0]   max_idx;
  logic [idxWidth:0]     cnt_q;
  logic [idxWidth-1:0]   cnt_idx;
  logic [inputWidth-1:0] win_val;
  logic [idxWidth-1:0]   win_idx;

  logic load, step, emit, drop;

  assign cnt_idx = cnt_q[idxWidth-1:0];
  assign o_ready = (state_q != SCAN);

  max_cmp_stage #(
    .VAL_W(inputWidth),
    .IDX_W(idxWidth)
  ) u_cmp (
    .cur_val (max_val),
    .cur_idx (max_idx),
    .cand_val(cap_buf[cnt_idx]),
    .cand_idx(cnt_idx),
    .win_val (win_val),
    .win_idx (win_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    emit    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          load    = 1'b1;
          state_d = (numInput == 1) ? DONE : SCAN;
        end
      end
      SCAN: begin
        step = 1'b1;
        drop = i_valid;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        emit    = 1'b1;
        state_d = IDLE;
        // A frame arriving while the previous result is emitted starts immediately.
        if (i_valid) begin
          load    = 1'b1;
          state_d = (numInput == 1) ? DONE : SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < numInput; k++) cap_buf[k] <= '0;
      max_val   <= '0;
      max_idx   <= '0;
      cnt_q     <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_dropped <= 1'b0;
    end else begin
      o_valid   <= emit;
      o_dropped <= drop;
      if (emit) o_data <= max_idx;
      if (load) begin
        for (int k = 0; k < numInput; k++) cap_buf[k] <= i_data[k*inputWidth +: inputWidth];
        max_val <= i_data[inputWidth-1:0];
        max_idx <= '0;
        cnt_q   <= (idxWidth+1)'(1);
      end else if (step) begin
        max_val <= win_val;
        max_idx <= win_idx;
        if (cnt_q != LAST) cnt_q <= cnt_q + (idxWidth+1)'(1);
      end
    end
  end

`ifdef MAX_FINDER_SCORE_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_max_value <= '0;
      frame_cnt_q <= '0;
    end else if (emit) begin
      o_max_value <= max_val;
      if (frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end
`endif

endmodule
